// File: rtl/timer_cmp_n_if.sv
// Load/clear strobes and registered counter/compare/event outputs of timer_cmp_n.
// The master drives the strobes and load values; the slave (the timer) drives the vout_* signals.
interface timer_cmp_n_if #(
    parameter int N = 32
);
    logic         en;
    logic         ld_cnt;
    logic [N-1:0] vin_cnt;
    logic         ld_cmp;
    logic [N-1:0] vin_cmp;
    logic         clr;
    logic [N-1:0] vout_cnt;
    logic [N-1:0] vout_cmp;
    logic         vout_match;
    logic         vout_irq;
    logic         vout_wrap;

    // Strobes are level-sampled on every rising edge; there is no back-pressure.
    modport master (
        output en, ld_cnt, vin_cnt, ld_cmp, vin_cmp, clr,
        input  vout_cnt, vout_cmp, vout_match, vout_irq, vout_wrap
    );

    modport slave (
        input  en, ld_cnt, vin_cnt, ld_cmp, vin_cmp, clr,
        output vout_cnt, vout_cmp, vout_match, vout_irq, vout_wrap
    );
endinterface

// File: rtl/timer_cmp_n.sv
// Free-running N-bit counter with a loadable compare register.
// Turns cnt == cmp into a one-cycle match pulse, a sticky irq flag and a wrap pulse.
module timer_cmp_n #(
    parameter int           N           = 32,
    parameter logic [N-1:0] M           = '0,
    parameter bit           AUTO_RELOAD = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    timer_cmp_n_if.slave bus
);
    logic [N-1:0] cnt;
    logic [N-1:0] cmp;
    logic [N-1:0] cnt_next;
    logic         hit;
    logic         hit_q;
    logic         match;
    logic         irq;
    logic         wrap;
    logic         wrap_next;
    logic         reload;

    assign hit    = (cnt == cmp);
    // hit_q resets to 1 so that leaving reset with cnt == cmp is not an entry event.
    assign match  = hit & ~hit_q;
    assign reload = bus.en & AUTO_RELOAD & hit;

    always_comb begin
        cnt_next  = cnt;
        wrap_next = 1'b0;
        if (bus.ld_cnt) begin
            cnt_next = bus.vin_cnt;
        end else if (reload) begin
            cnt_next = '0;
        end else if (bus.en) begin
            cnt_next  = cnt + N'(1);
            wrap_next = (cnt == {N{1'b1}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            cmp   <= M;
            hit_q <= 1'b1;
            irq   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            hit_q <= hit;
            wrap  <= wrap_next;
            if (bus.ld_cmp) begin
                cmp <= bus.vin_cmp;
            end
            // A match in the same cycle as clr wins, so no event is dropped.
            if (match) begin
                irq <= 1'b1;
            end else if (bus.clr) begin
                irq <= 1'b0;
            end
        end
    end

    assign bus.vout_cnt   = cnt;
    assign bus.vout_cmp   = cmp;
    assign bus.vout_match = match;
    assign bus.vout_irq   = irq;
    assign bus.vout_wrap  = wrap;
endmodule

// File: tb/tb_timer_cmp_n.sv
// Bench for timer_cmp_n: a one-shot 32-bit instance (M = 0) and a periodic 8-bit instance (M = 3),
// both checked every cycle against an arithmetic reference model.
module tb_timer_cmp_n;
    logic clk;
    logic rst_n;

    timer_cmp_n_if #(.N(32)) if_a ();
    timer_cmp_n_if #(.N(8))  if_b ();

    timer_cmp_n #(.N(32), .M(32'd0), .AUTO_RELOAD(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    timer_cmp_n #(.N(8), .M(8'd3), .AUTO_RELOAD(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: index 0 = dut_a, 1 = dut_b
    int     nbits   [2] = '{32, 8};
    bit     reload_m[2] = '{1'b0, 1'b1};
    longint mval    [2] = '{0, 3};
    longint m_cnt   [2];
    longint m_cmp   [2];
    bit     m_prev  [2];
    bit     m_irq   [2];
    bit     m_wrap  [2];

    int n_checks = 0;
    int n_fails  = 0;

    function automatic longint top_val(input int k);
        return (longint'(1) << nbits[k]) - 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_cmp[k]  = mval[k];
            m_prev[k] = 1'b1;
            m_irq[k]  = 1'b0;
            m_wrap[k] = 1'b0;
        end
    endtask

    function automatic bit exp_match(input int k);
        return (m_cnt[k] == m_cmp[k]) && !m_prev[k];
    endfunction

    task automatic model_step(input int k, input bit en, input bit lc, input longint vc,
                              input bit lm, input longint vm, input bit clr);
        bit     eq;
        bit     mt;
        longint nxt;
        eq  = (m_cnt[k] == m_cmp[k]);
        mt  = exp_match(k);
        nxt = m_cnt[k];
        m_wrap[k] = 1'b0;
        if (lc) begin
            nxt = vc & top_val(k);
        end else if (en && reload_m[k] && eq) begin
            nxt = 0;
        end else if (en) begin
            nxt = (m_cnt[k] + 1) % (top_val(k) + 1);
            m_wrap[k] = (m_cnt[k] == top_val(k));
        end
        m_irq[k]  = mt || (m_irq[k] && !clr);
        m_prev[k] = eq;
        m_cnt[k]  = nxt;
        if (lm) m_cmp[k] = vm & top_val(k);
    endtask

    // scoreboard check
    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k);
        longint oc, om;
        longint mt, iq, wr;
        if (k == 0) begin
            oc = longint'(if_a.vout_cnt); om = longint'(if_a.vout_cmp);
            mt = longint'(if_a.vout_match); iq = longint'(if_a.vout_irq); wr = longint'(if_a.vout_wrap);
        end else begin
            oc = longint'(if_b.vout_cnt); om = longint'(if_b.vout_cmp);
            mt = longint'(if_b.vout_match); iq = longint'(if_b.vout_irq); wr = longint'(if_b.vout_wrap);
        end
        chk($sformatf("dut%0d_cnt", k), oc, m_cnt[k]);
        chk($sformatf("dut%0d_cmp", k), om, m_cmp[k]);
        chk($sformatf("dut%0d_match", k), mt, longint'(exp_match(k)));
        chk($sformatf("dut%0d_irq", k), iq, longint'(m_irq[k]));
        chk($sformatf("dut%0d_wrap", k), wr, longint'(m_wrap[k]));
    endtask

    // driver: one clock cycle on dut k, the other instance idles; called at a falling edge
    task automatic cycle(input int k, input bit en, input bit lc, input longint vc,
                         input bit lm, input longint vm, input bit clr);
        if_a.en = 1'b0; if_a.ld_cnt = 1'b0; if_a.vin_cnt = '0;
        if_a.ld_cmp = 1'b0; if_a.vin_cmp = '0; if_a.clr = 1'b0;
        if_b.en = 1'b0; if_b.ld_cnt = 1'b0; if_b.vin_cnt = '0;
        if_b.ld_cmp = 1'b0; if_b.vin_cmp = '0; if_b.clr = 1'b0;
        if (k == 0) begin
            if_a.en = en; if_a.ld_cnt = lc; if_a.vin_cnt = 32'(vc);
            if_a.ld_cmp = lm; if_a.vin_cmp = 32'(vm); if_a.clr = clr;
        end else begin
            if_b.en = en; if_b.ld_cnt = lc; if_b.vin_cnt = 8'(vc);
            if_b.ld_cmp = lm; if_b.vin_cmp = 8'(vm); if_b.clr = clr;
        end
        @(posedge clk);
        model_step(k, en, lc, vc, lm, vm, clr);
        model_step(1 - k, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic run_en(input int k, input int cycles);
        for (int i = 0; i < cycles; i++) cycle(k, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        longint vc, vm;
        bit     en, lc, lm, cl;

        // reset with idle inputs
        rst_n = 1'b0;
        if_a.en = 1'b0; if_a.ld_cnt = 1'b0; if_a.vin_cnt = '0;
        if_a.ld_cmp = 1'b0; if_a.vin_cmp = '0; if_a.clr = 1'b0;
        if_b.en = 1'b0; if_b.ld_cnt = 1'b0; if_b.vin_cnt = '0;
        if_b.ld_cmp = 1'b0; if_b.vin_cmp = '0; if_b.clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_dut(0);
        check_dut(1);
        rst_n = 1'b1;

        // idle after reset: everything quiet for 10 cycles
        for (int i = 0; i < 10; i++) cycle(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

        // compare at 5, count up from 0
        cycle(0, 1'b0, 1'b0, 0, 1'b1, 5, 1'b0);
        run_en(0, 5);
        chk("a_cnt_at_match", longint'(if_a.vout_cnt), 5);
        chk("a_match_pulse", longint'(if_a.vout_match), 1);
        run_en(0, 3);
        chk("a_irq_held", longint'(if_a.vout_irq), 1);
        chk("a_match_gone", longint'(if_a.vout_match), 0);
        cycle(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        chk("a_irq_cleared", longint'(if_a.vout_irq), 0);

        // overflow: all-ones minus one, then two increments
        cycle(0, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 0, 1'b0);
        run_en(0, 2);
        chk("a_wrap_at_zero", longint'(if_a.vout_wrap), 1);
        run_en(0, 2);

        // clr coincident with a match pulse keeps the flag
        cycle(0, 1'b0, 1'b1, 19, 1'b1, 20, 1'b0);
        cycle(0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("a_match_at20", longint'(if_a.vout_match), 1);
        cycle(0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
        chk("a_irq_survives_clr", longint'(if_a.vout_irq), 1);
        cycle(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

        // load cnt = cmp = 7 with en low: one pulse, then quiet
        cycle(0, 1'b0, 1'b1, 7, 1'b1, 7, 1'b0);
        chk("a_load_match", longint'(if_a.vout_match), 1);
        for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

        // periodic instance: cmp = 3 from reset, period of 4
        run_en(1, 12);
        cycle(1, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1);
        run_en(1, 6);

        // asynchronous reset mid-count with irq set
        cycle(0, 1'b0, 1'b1, 0, 1'b1, 4, 1'b1);
        run_en(0, 9);
        chk("a_cnt_before_rst", longint'(if_a.vout_cnt), 9);
        chk("a_irq_before_rst", longint'(if_a.vout_irq), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        rst_n = 1'b1;
        run_en(0, 3);

        // randomized traffic on both instances
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 400; i++) begin
                en = ($urandom_range(0, 3) != 0);
                lc = ($urandom_range(0, 15) == 0);
                lm = ($urandom_range(0, 19) == 0);
                cl = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 2))
                    0:       vc = m_cmp[k] - longint'($urandom_range(0, 4));
                    1:       vc = top_val(k) - longint'($urandom_range(0, 3));
                    default: vc = longint'($urandom);
                endcase
                vm = (k == 1) ? longint'($urandom_range(0, 255)) : longint'($urandom_range(0, 40));
                cycle(k, en, lc, vc, lm, vm, cl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
